// File: rtl/ccm_linebuf_ctrl_pkg.sv
// Shared parameters, FSM encoding and output payload for the CCM line-buffer controller.
package ccm_linebuf_ctrl_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned MAX_LEN   = 256;
  localparam int unsigned PARK_ADDR = 256;

  typedef enum logic [1:0] {
    LB_IDLE = 2'd0,
    LB_FILL = 2'd1,
    LB_STRM = 2'd2
  } lb_state_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] cur;
    logic              eol;
    logic              row0;
  } lb_out_t;

  // Row lengths of 0 or beyond the ring size fall back to a full-size ring.
  function automatic logic [ADDR_W-1:0] clamp_len(input logic [ADDR_W-1:0] len);
    if (len == '0 || len > ADDR_W'(MAX_LEN)) begin
      return ADDR_W'(MAX_LEN);
    end
    return len;
  endfunction

endpackage

// File: rtl/ccm_linebuf_ctrl_if.sv
// Pixel-in, register-array and pair-out signals of the line-buffer controller.
interface ccm_linebuf_ctrl_if;
  import ccm_linebuf_ctrl_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_cur;
  logic [DATA_W-1:0] out_prev;
  logic              out_eol;
  logic              out_row0;

  modport master (
    input  in_valid, in_data, rd_data,
    output wr_ptr, rd_ptr, wr_data,
    output out_valid, out_cur, out_prev, out_eol, out_row0
  );

  modport slave (
    output in_valid, in_data, rd_data,
    input  wr_ptr, rd_ptr, wr_data,
    input  out_valid, out_cur, out_prev, out_eol, out_row0
  );

endinterface

// File: rtl/ccm_ring_ptr.sv
// Ring head/column pointer over entries 0..len-1 with last-column flag.
module ccm_ring_ptr
  import ccm_linebuf_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic [ADDR_W-1:0] head_o,
  output logic              eol_c_o
);

  logic [ADDR_W-1:0] head_q;
  logic [ADDR_W-1:0] head_d;

  // Head doubles as the column index since the ring is exactly one row long.
  assign eol_c_o = (head_q == len_i - ADDR_W'(1));
  assign head_o  = head_q;

  always_comb begin
    head_d = head_q;
    if (clr_i) begin
      head_d = '0;
    end else if (adv_i) begin
      head_d = eol_c_o ? '0 : head_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
    end else begin
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/ccm_linebuf_ctrl.sv
// One-row delay line controller around the 257-entry CCM register array.
// Optional top zero padding of the first row: define CCM_LB_ZERO_PAD_EN.
module ccm_linebuf_ctrl
  import ccm_linebuf_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] row_len_i,
  input  logic              flush_i,
  ccm_linebuf_ctrl_if.master lb
);

`ifdef CCM_LB_ZERO_PAD_EN
  localparam bit ZeroPadEn = 1'b1;
`else
  localparam bit ZeroPadEn = 1'b0;
`endif

  lb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  lb_out_t           out_q, out_d;
  logic [ADDR_W-1:0] eff_len_c;
  logic [ADDR_W-1:0] head;
  logic              eol_c;
  logic              accept_c;
  logic              pair_valid_c;

  // A pixel coinciding with flush is dropped: parked, not counted.
  assign accept_c  = lb.in_valid & ~flush_i;
  assign eff_len_c = (state_q == LB_IDLE) ? clamp_len(row_len_i) : len_q;

  ccm_ring_ptr u_ring_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv_i   (accept_c),
    .clr_i   (flush_i),
    .len_i   (eff_len_c),
    .head_o  (head),
    .eol_c_o (eol_c)
  );

  // The array writes every clock, so idle cycles land on the scratch entry.
  assign lb.wr_ptr  = accept_c ? head : ADDR_W'(PARK_ADDR);
  assign lb.rd_ptr  = head;
  assign lb.wr_data = lb.in_data;

  assign pair_valid_c = ZeroPadEn | (state_q == LB_STRM);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    fill_d  = fill_q;
    if (flush_i) begin
      state_d = LB_IDLE;
      fill_d  = '0;
    end else if (accept_c) begin
      case (state_q)
        LB_IDLE: begin
          len_d   = eff_len_c;
          fill_d  = ADDR_W'(1);
          state_d = (eff_len_c == ADDR_W'(1)) ? LB_STRM : LB_FILL;
        end
        LB_FILL: begin
          fill_d = fill_q + ADDR_W'(1);
          if (fill_q + ADDR_W'(1) == len_q) begin
            state_d = LB_STRM;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    out_d = out_q;
    if (flush_i) begin
      out_d.valid = 1'b0;
      out_d.eol   = 1'b0;
      out_d.row0  = 1'b1;
    end else if (accept_c) begin
      out_d.valid = pair_valid_c;
      out_d.cur   = lb.in_data;
      out_d.eol   = pair_valid_c & eol_c;
      out_d.row0  = (state_q != LB_STRM);
    end else begin
      out_d.valid = 1'b0;
      out_d.eol   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LB_IDLE;
      len_q   <= ADDR_W'(MAX_LEN);
      fill_q  <= '0;
      out_q   <= '{valid: 1'b0, cur: '0, eol: 1'b0, row0: 1'b1};
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
    end
  end

  assign lb.out_valid = out_q.valid;
  assign lb.out_cur   = out_q.cur;
  assign lb.out_eol   = out_q.eol;
  assign lb.out_row0  = out_q.row0;
  // First-row pairs see zero above them when padding is enabled.
  assign lb.out_prev  = (ZeroPadEn && out_q.row0) ? '0 : lb.rd_data;

endmodule

// File: tb/tb_ccm_linebuf_ctrl.sv
// Bench for ccm_linebuf_ctrl with a register-array model and a row-history reference.
module tb_ccm_linebuf_ctrl;

`ifdef CCM_LB_ZERO_PAD_EN
  localparam bit ZpEn = 1'b1;
`else
  localparam bit ZpEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [8:0] row_len = 9'd4;
  logic       flush = 1'b0;

  always #5 clk = ~clk;

  ccm_linebuf_ctrl_if lb();

  ccm_linebuf_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_len_i (row_len),
    .flush_i   (flush),
    .lb        (lb)
  );

  // Register array: writes every clock, registered read-before-write, cleared by reset.
  logic [7:0] mem [0:256];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 257; i++) mem[i] <= 8'd0;
      lb.rd_data <= 8'd0;
    end else begin
      lb.rd_data <= mem[lb.rd_ptr];
      mem[lb.wr_ptr] <= lb.wr_data;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  // Reference: pixel n since restart pairs with pixel n-L; row r = n / L.
  int m_len = 256;
  int m_n = 0;
  bit m_started = 1'b0;
  int hist [512];
  bit e_valid = 1'b0;
  bit e_eol = 1'b0;
  bit e_row0 = 1'b1;
  int e_cur = 0;
  int e_prev = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("out_valid", 32'(lb.out_valid), 32'(e_valid));
    check_eq("out_eol", 32'(lb.out_eol), 32'(e_eol));
    check_eq("out_row0", 32'(lb.out_row0), 32'(e_row0));
    if (e_valid) begin
      check_eq("out_cur", 32'(lb.out_cur), 32'(e_cur));
      check_eq("out_prev", 32'(lb.out_prev), 32'(e_prev));
    end
  endtask

  // Called at a falling edge: check last cycle's pair, drive this cycle, advance model.
  task automatic step(input bit v, input int d, input bit fl, input int rl);
    int head_exp;
    check_outputs();
    lb.in_valid = v;
    lb.in_data  = 8'(d);
    flush       = fl;
    row_len     = 9'(rl);
    head_exp    = m_started ? (m_n % m_len) : 0;
    #1;
    check_eq("wr_data", 32'(lb.wr_data), 32'(d & 255));
    if (v && !fl) begin
      check_eq("wr_ptr", 32'(lb.wr_ptr), 32'(head_exp));
      check_eq("rd_ptr", 32'(lb.rd_ptr), 32'(head_exp));
      if (!m_started) begin
        m_len = (rl == 0 || rl > 256) ? 256 : rl;
        m_started = 1'b1;
        m_n = 0;
      end
      hist[m_n % 512] = d & 255;
      e_valid = ZpEn || (m_n >= m_len);
      e_cur   = d & 255;
      e_prev  = (m_n >= m_len) ? hist[(m_n - m_len) % 512] : 0;
      e_eol   = e_valid && ((m_n % m_len) == m_len - 1);
      e_row0  = (m_n < m_len);
      m_n++;
    end else begin
      check_eq("wr_ptr_park", 32'(lb.wr_ptr), 32'd256);
      check_eq("rd_ptr_idle", 32'(lb.rd_ptr), 32'(head_exp));
      e_valid = 1'b0;
      e_eol   = 1'b0;
      if (fl) begin
        m_started = 1'b0;
        m_n = 0;
        e_row0 = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    lb.in_valid = 1'b0;
    lb.in_data = 8'd0;
    flush = 1'b0;
    #1;
    m_started = 1'b0;
    m_n = 0;
    e_valid = 1'b0;
    e_eol = 1'b0;
    e_row0 = 1'b1;
    e_cur = 0;
    e_prev = 0;
    check_eq("rst_valid", 32'(lb.out_valid), 32'd0);
    check_eq("rst_eol", 32'(lb.out_eol), 32'd0);
    check_eq("rst_row0", 32'(lb.out_row0), 32'd1);
    check_eq("rst_cur", 32'(lb.out_cur), 32'd0);
    check_eq("rst_prev", 32'(lb.out_prev), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    lb.in_valid = 1'b0;
    lb.in_data = 8'd0;
    @(negedge clk);
    apply_reset();

    // Continuous row of 4.
    for (int i = 1; i <= 12; i++) step(1'b1, i, 1'b0, 4);
    step(1'b0, 0, 1'b0, 4);

    // Same stream with bubbles.
    step(1'b0, 0, 1'b1, 4);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, i, 1'b0, 4);
      step(1'b0, 0, 1'b0, 4);
    end

    // Full-size ring across two rows.
    step(1'b0, 0, 1'b1, 256);
    for (int i = 0; i < 512; i++) step(1'b1, i % 256, 1'b0, 256);
    step(1'b0, 0, 1'b0, 256);

    // Flush with a valid pixel mid row 2, then a new row length; later changes ignored.
    step(1'b0, 0, 1'b1, 4);
    for (int i = 1; i <= 6; i++) step(1'b1, i, 1'b0, 4);
    step(1'b1, 99, 1'b1, 4);
    step(1'b1, 50, 1'b0, 3);
    for (int i = 51; i < 60; i++) step(1'b1, i, 1'b0, int'($urandom_range(0, 511)));
    step(1'b0, 0, 1'b0, 3);

    // Reset in the middle of a row.
    step(1'b0, 0, 1'b1, 4);
    for (int i = 1; i <= 7; i++) step(1'b1, i, 1'b0, 4);
    apply_reset();
    for (int i = 20; i < 30; i++) step(1'b1, i, 1'b0, 4);
    step(1'b0, 0, 1'b0, 4);

    // Random segments: random length (incl. clamped values), bubbles, sporadic flush.
    for (int seg = 0; seg < 8; seg++) begin
      int len_sel;
      len_sel = (seg % 3 == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(1, 8));
      step(1'b0, 0, 1'b1, len_sel);
      for (int c = 0; c < 200; c++) begin
        bit v;
        bit fl;
        int rl;
        v  = ($urandom % 10) < 7;
        fl = ($urandom % 60) == 0;
        rl = m_started ? int'($urandom_range(0, 511)) : len_sel;
        step(v, int'($urandom % 256), fl, rl);
      end
    end
    step(1'b0, 0, 1'b0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ccm_linebuf_ctrl.md
Name: ccm_linebuf_ctrl

Overview:
Pointer/handshake controller that turns the 257-entry CCM register array into a one-row delay line (line buffer) for the convolution window.
- Drives the array's write pointer, read pointer and write data.
- Takes back the array's 1-cycle-latency read data.
- Presents each row-aligned pair (current pixel, same column one row earlier) downstream with a valid strobe.
- Sits between the upstream pixel stream and the array; its outputs feed the CCM window/MAC stage.

Parameters:
- DATA_W, 8, pixel width; matches the array data width.
- ADDR_W, 9, pointer width; matches the array rd_ptr/wr_ptr.
- MAX_LEN, 256, maximum row length; ring occupies entries 0..MAX_LEN-1.
- PARK_ADDR, 256, scratch entry written when no valid input is present.

Ports:
- clk  in  1  clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- row_len  in  9  row length, 1..MAX_LEN; sampled only when state is IDLE.
- flush  in  1  synchronous restart: return to IDLE, zero counters.
- in_valid  in  1  input pixel valid; no backpressure, consumed every valid cycle.
- in_data  in  DATA_W  input pixel.
- wr_ptr  out  ADDR_W  to array wr_ptr (combinational).
- rd_ptr  out  ADDR_W  to array rd_ptr (combinational).
- wr_data  out  DATA_W  to array data_in (combinational = in_data).
- rd_data  in  DATA_W  from array data_out (registered inside the array, 1-cycle latency).
- out_valid  out  1  output pair valid.
- out_cur  out  DATA_W  current pixel, delayed 1 cycle to align with rd_data.
- out_prev  out  DATA_W  pixel from the same column one row earlier.
- out_eol  out  1  qualifies the last column of a row (only with out_valid).
- out_row0  out  1  output belongs to the first row after flush/reset.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; head=0, col=0, fill=0, len_q=MAX_LEN; out_valid=0, out_cur=0, out_eol=0, out_row0=1. out_prev follows rd_data, which the array also resets to 0.
- Array writes every clock unconditionally. Therefore:
  - in_valid=0: wr_ptr=PARK_ADDR. Ring contents are never corrupted by idle cycles.
  - in_valid=1: wr_ptr=head and rd_ptr=head. The array returns the old value (read-before-write) on the next cycle.
  - in_valid=0: rd_ptr=head (don't-care value, not consumed).
- Ring pointer: head advances on each valid; wraps to 0 after len_q-1. col tracks head; out_eol is registered (col==len_q-1) on a valid cycle.
- States:
  - IDLE: on in_valid, latch len_q=row_len (0 or >MAX_LEN clamps to MAX_LEN), go to FILL.
  - FILL: counts valids in fill. When fill reaches len_q (the first valid of row 1), go to STREAM.
  - STREAM: steady state until flush.
- Latency: out_* registered one cycle after the accepting in_valid cycle. out_prev = rd_data, the array output in that same cycle.
- out_valid: pipelined in_valid, qualified by state==STREAM at the accepting cycle. No output during the first row unless the optional feature is enabled.
- out_row0=1 for pairs produced while in FILL; 0 once STREAM has been entered.
- flush:
  - Highest priority. If flush and in_valid occur together, the pixel is dropped.
  - Next cycle: IDLE, counters zeroed, out_valid=0. The pipelined out register still emits a pair already accepted the cycle before.
- row_len changes outside IDLE are ignored until the next flush.
- Reset mid-row: everything returns to reset values immediately. Ring data is lost (array cleared).

Optional Feature:
- CCM_LB_ZERO_PAD_EN defined:
  - out_valid is also asserted for pairs accepted in FILL.
  - out_prev is forced to 0 for those pairs (top zero padding).
  - Result: one output per input from the first pixel.
- Undefined:
  - FILL outputs are suppressed, as described in Behaviour.

Decomposition:
- Shared package/include (para.v): DATA_W, ADDR_W, MAX_LEN, PARK_ADDR, and state encodings LB_IDLE=2'd0, LB_FILL=2'd1, LB_STRM=2'd2.
- Sub-module: ccm_ring_ptr. Holds head, col and wrap logic, and produces the eol flag. The FSM and output register stay in ccm_linebuf_ctrl.
- Integrate with register_array in the bench.

Test Plan:
- Stream, row_len=4, pixels 1..12, in_valid always 1 -> first out_valid on the cycle after pixel 5; pairs (5,1),(6,2),(7,3),(8,4),...,(12,8); out_eol with (8,4) and (12,8).
- Same stream with in_valid toggling 1,0 -> identical pair sequence; wr_ptr=256 on every idle cycle; ring entries 0..3 unchanged on idle cycles.
- row_len=256, 512 pixels (value = index mod 256) -> out_prev equals out_cur for all 256 outputs; head wraps 255->0 and out_eol asserts once per row.
- flush asserted with in_valid=1 mid-row 2 -> that pixel is not written; next cycle out_valid=0 and state IDLE; new row_len=3 latched on the next valid.
- rst_n low for 1 cycle mid-stream -> all outputs reset immediately; out_row0=1; no out_valid until a full row is refilled.
- With CCM_LB_ZERO_PAD_EN, row_len=4, pixels 1..8 -> outputs (1,0),(2,0),(3,0),(4,0),(5,1)...(8,4); out_row0=1 for the first four.
